insn_encoder: RTL and testbench
===============================

Name: insn_encoder

Overview:
- Instruction encoder: the inverse of the immediate/field decode path in the decode stage.
- Accepts decoded fields (format, opcode, regs, functs, 32-bit immediate) over a valid/ready request port.
- Range-checks the immediate, packs an RV32I instruction word and tags it with a sequential fetch address.
- Buffers results in a small FIFO toward an instruction-memory writer port. Used by the program loader and by the self-checking decode bench.

Parameters:
- DWIDTH, 32, instruction/immediate width.
- AWIDTH, 32, address width.
- BASE_ADDR, 32'h0100_0000, first address after reset or restart.
- DEPTH, 4, output FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- restart_i  in  1  synchronous: flush FIFO, reload address counter to BASE_ADDR.
- clear_err_i  in  1  synchronous: clear err_o.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- fmt_i  in  3  format: 0=R 1=I 2=S 3=B 4=U 5=J; 6, 7 illegal.
- opcode_i  in  7  opcode field.
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- funct3_i  in  3  funct3 field.
- funct7_i  in  7  funct7 field.
- imm_i  in  DWIDTH  immediate, full sign-extended value (U: upper-aligned value).
- insn_valid_o  out  1  FIFO head valid.
- insn_ready_i  in  1  downstream accepts head.
- insn_o  out  DWIDTH  encoded instruction at head.
- addr_o  out  AWIDTH  address of head instruction.
- err_o  out  1  sticky range/format error.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, reset=0): FIFO empty, addr counter=BASE_ADDR, err_o=0, insn_valid_o=0, insn_o=0, addr_o=0, count_o=0. req_ready_o=0 while reset is asserted, and 1 from the first clk after release.
- req_ready_o = (count_o < DEPTH) or (count_o == DEPTH and insn_valid_o and insn_ready_i). Pop-and-push in the same cycle when full is allowed.
- Accept = req_valid_i & req_ready_o. Encoding is combinational on the request fields. On accept, the FIFO entry is written at the rising edge, so insn_valid_o rises the following cycle (1-cycle latency).
- Encoding:
  - R = {funct7,rs2,rs1,funct3,rd,opcode}
  - I = {imm[11:0],rs1,funct3,rd,opcode}
  - S = {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B = {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U = {imm[31:12],rd,opcode}
  - J = {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- Range checks (fail → illegal):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - R: imm ignored.
  - fmt 6/7 always illegal.
- Illegal request: accepted (handshake completes), not enqueued, address counter not advanced, err_o set next cycle.
- Legal request: entry {addr_ctr, insn}; addr_ctr += 4, wrapping modulo 2^AWIDTH.
- Pop on insn_valid_o & insn_ready_i. insn_o/addr_o hold stable while valid and not ready. When empty, insn_o/addr_o hold their last value.
- Simultaneous push and pop: count unchanged.
- restart_i has priority over accept/pop in that cycle:
  - FIFO emptied, addr_ctr=BASE_ADDR.
  - A concurrent request is not accepted (req_ready_o=0 that cycle).
  - err_o unaffected.
- clear_err_i and a new error in the same cycle: err_o stays 1 (set wins).
- Reset mid-stream: all state dropped immediately; no partial entry survives.

Test Plan:
- fmt=I, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5 → next cycle insn_o=0x00500093, addr_o=0x01000000, count_o=1.
- Back-to-back legal requests:
  - S: opcode=0x23, rs1=1, rs2=2, f3=2, imm=8 → 0x0020A423.
  - U: opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7.
  - Expected addresses 0x01000000, 0x01000004.
- Branch and jump encodings:
  - B: opcode=0x63, rs1=1, rs2=2, f3=0, imm=-4 → 0xFE208EE3.
  - J: opcode=0x6F, rd=1, imm=0x800 → 0x001000EF.
- Illegal immediates:
  - I with imm=0x800, then B with imm=3 → both accepted, neither enqueued, err_o=1, counter unchanged.
  - clear_err_i → err_o=0.
- Backpressure: hold insn_ready_i=0, issue 5 legal requests with DEPTH=4.
  - Expect req_ready_o=0 after 4, and insn_o/addr_o stable.
  - Raise insn_ready_i → 5th request accepted in the pop cycle, addresses in order.
- Control edge cases:
  - restart_i with 3 entries queued → count_o=0 next cycle, next legal request gets 0x01000000.
  - reset pulse mid-stream → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/insn_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// insn_encoder
//   Packs decoded RV32I fields into instruction words and tags them with
//   sequential fetch addresses, buffered through a small output FIFO.
// Revision: 1.0
// ============================================================================
module insn_encoder #(
    parameter int                DWIDTH    = 32,
    parameter int                AWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
    parameter int                DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     restart_i,
    input  logic                     clear_err_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [2:0]               fmt_i,
    input  logic [6:0]               opcode_i,
    input  logic [4:0]               rd_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    input  logic [2:0]               funct3_i,
    input  logic [6:0]               funct7_i,
    input  logic [DWIDTH-1:0]        imm_i,
    output logic                     insn_valid_o,
    input  logic                     insn_ready_i,
    output logic [DWIDTH-1:0]        insn_o,
    output logic [AWIDTH-1:0]        addr_o,
    output logic                     err_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [DWIDTH-1:0] enc_word;
    logic              enc_legal;
    logic              imm12_ok;
    logic              imm13_ok;
    logic              imm21_ok;
    logic              upper_ok;

    logic [DWIDTH-1:0] mem_insn [DEPTH];
    logic [AWIDTH-1:0] mem_addr [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [AWIDTH-1:0] addr_ctr;
    logic [DWIDTH-1:0] last_insn;
    logic [AWIDTH-1:0] last_addr;
    logic              err;
    logic              ready_en;

    logic              empty;
    logic              full;
    logic              accept;
    logic              push;
    logic              pop;
    logic              new_err;

    // Each immediate must be representable in its format's sign-extended field.
    assign imm12_ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign imm13_ok = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];
    assign imm21_ok = ((&imm_i[31:20]) | ~(|imm_i[31:20])) & ~imm_i[0];
    assign upper_ok = ~(|imm_i[11:0]);

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        case (fmt_i)
            FMT_R: begin
                enc_word  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
                enc_legal = 1'b1;
            end
            FMT_I: begin
                enc_word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                enc_legal = imm12_ok;
            end
            FMT_S: begin
                enc_word  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                enc_legal = imm12_ok;
            end
            FMT_B: begin
                enc_word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], opcode_i};
                enc_legal = imm13_ok;
            end
            FMT_U: begin
                enc_word  = {imm_i[31:12], rd_i, opcode_i};
                enc_legal = upper_ok;
            end
            FMT_J: begin
                enc_word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                enc_legal = imm21_ok;
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // When full the head is always valid, so a ready sink frees a slot this cycle.
    assign req_ready_o = ready_en & ~restart_i & (~full | insn_ready_i);
    assign accept      = req_valid_i & req_ready_o;
    assign push        = accept & enc_legal;
    assign new_err     = accept & ~enc_legal;
    assign pop         = ~empty & insn_ready_i & ~restart_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            addr_ctr  <= BASE_ADDR;
            last_insn <= '0;
            last_addr <= '0;
            err       <= 1'b0;
            ready_en  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (restart_i) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                addr_ctr <= BASE_ADDR;
                if (!empty) begin
                    last_insn <= mem_insn[rd_ptr];
                    last_addr <= mem_addr[rd_ptr];
                end
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    addr_ctr <= addr_ctr + AWIDTH'(4);
                end
                if (pop) begin
                    rd_ptr    <= rd_ptr + PW'(1);
                    last_insn <= mem_insn[rd_ptr];
                    last_addr <= mem_addr[rd_ptr];
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
            if (new_err) begin
                err <= 1'b1;
            end else if (clear_err_i) begin
                err <= 1'b0;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_insn[wr_ptr] <= enc_word;
            mem_addr[wr_ptr] <= addr_ctr;
        end
    end

    assign insn_valid_o = ~empty;
    assign insn_o       = empty ? last_insn : mem_insn[rd_ptr];
    assign addr_o       = empty ? last_addr : mem_addr[rd_ptr];
    assign err_o        = err;
    assign count_o      = count;

endmodule
`default_nettype wire

// File: tb/tb_insn_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// Randomized and directed check of insn_encoder against a queue-based model.
module tb_insn_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart_i, clear_err_i, req_valid_i, req_ready_o;
    logic [2:0]  fmt_i, funct3_i;
    logic [6:0]  opcode_i, funct7_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [31:0] imm_i;
    logic        insn_valid_o, insn_ready_i, err_o;
    logic [31:0] insn_o, addr_o;
    logic [2:0]  count_o;

    always #5 clk = ~clk;

    insn_encoder #(.DWIDTH(32), .AWIDTH(32), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .restart_i(restart_i), .clear_err_i(clear_err_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .fmt_i(fmt_i),
        .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
        .insn_valid_o(insn_valid_o), .insn_ready_i(insn_ready_i), .insn_o(insn_o),
        .addr_o(addr_o), .err_o(err_o), .count_o(count_o)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] q[$];
    logic [31:0] m_addr, last_insn, last_addr;
    logic        m_err, m_rdy_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Legality expressed as numeric ranges of the signed immediate.
    function automatic bit legal(input logic [2:0] f, input logic [31:0] im);
        int s;
        s = $signed(im);
        case (f)
            3'd0:       return 1'b1;
            3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
            3'd3:       return (s >= -4096) && (s <= 4095) && (im[0] == 1'b0);
            3'd4:       return (im % 4096) == 0;
            3'd5:       return (s >= -(1 << 20)) && (s < (1 << 20)) && (im[0] == 1'b0);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] enc(input logic [2:0] f, input logic [6:0] op,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] im);
        case (f)
            3'd0:    return {f7, rs2, rs1, f3, rd, op};
            3'd1:    return {im[11:0], rs1, f3, rd, op};
            3'd2:    return {im[11:5], rs2, rs1, f3, im[4:0], op};
            3'd3:    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], op};
            3'd4:    return {im[31:12], rd, op};
            3'd5:    return {im[20], im[10:1], im[11], im[19:12], rd, op};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_addr    = BASE;
        last_insn = 32'h0;
        last_addr = 32'h0;
        m_err     = 1'b0;
        m_rdy_en  = 1'b0;
    endtask

    // One clock: checks ready before the edge, advances the model, checks outputs after.
    task automatic step();
        bit exp_rdy, acc, lg;
        logic [31:0] w;
        #1;
        exp_rdy = m_rdy_en && !restart_i && ((q.size() < DEPTH) || insn_ready_i);
        check("req_ready", {31'b0, req_ready_o}, {31'b0, exp_rdy});
        acc = req_valid_i && exp_rdy;
        lg  = legal(fmt_i, imm_i);
        w   = enc(fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);
        @(posedge clk);
        m_rdy_en = 1'b1;
        if (restart_i) begin
            q.delete();
            m_addr = BASE;
        end else begin
            if (q.size() > 0 && insn_ready_i) void'(q.pop_front());
            if (acc && lg) begin
                q.push_back({m_addr, w});
                m_addr = m_addr + 32'd4;
            end
        end
        if (acc && !lg) m_err = 1'b1;
        else if (clear_err_i) m_err = 1'b0;
        if (q.size() > 0) begin
            last_insn = q[0][31:0];
            last_addr = q[0][63:32];
        end
        #1;
        check("insn_valid", {31'b0, insn_valid_o}, {31'b0, q.size() > 0});
        check("count", {29'b0, count_o}, q.size());
        check("insn", insn_o, last_insn);
        check("addr", addr_o, last_addr);
        check("err", {31'b0, err_o}, {31'b0, m_err});
    endtask

    task automatic idle();
        req_valid_i = 1'b0;
        restart_i   = 1'b0;
        clear_err_i = 1'b0;
    endtask

    task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
        req_valid_i = 1'b1;
        fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = im;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'b0, insn_valid_o}, 32'h0);
        check({tag, "_insn"}, insn_o, 32'h0);
        check({tag, "_addr"}, addr_o, 32'h0);
        check({tag, "_count"}, {29'b0, count_o}, 32'h0);
        check({tag, "_err"}, {31'b0, err_o}, 32'h0);
        check({tag, "_ready"}, {31'b0, req_ready_o}, 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        insn_ready_i = 1'b0;
        idle();
        req(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
        req_valid_i = 1'b0;
        model_reset();
        #12;
        check_reset_outputs("por");
        reset = 1'b1;
        step();

        // Basic I-type encode
        req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        step();
        check("vecI_insn", insn_o, 32'h0050_0093);
        check("vecI_addr", addr_o, BASE);
        check("vecI_count", {29'b0, count_o}, 32'd1);
        idle(); insn_ready_i = 1'b1; step();

        // Back-to-back S and U after a restart
        restart_i = 1'b1; step(); idle();
        insn_ready_i = 1'b0;
        req(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        step();
        check("vecS_insn", insn_o, 32'h0020_A423);
        check("vecS_addr", addr_o, BASE);
        req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        step();
        idle(); insn_ready_i = 1'b1; step();
        check("vecU_insn", insn_o, 32'h1234_52B7);
        check("vecU_addr", addr_o, BASE + 32'd4);
        step();

        // Branch then jump, jump pushed in the cycle the branch pops
        restart_i = 1'b1; step(); idle();
        insn_ready_i = 1'b0;
        req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        step();
        check("vecB_insn", insn_o, 32'hFE20_8EE3);
        insn_ready_i = 1'b1;
        req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        step();
        check("vecJ_insn", insn_o, 32'h0010_00EF);
        check("vecJ_addr", addr_o, BASE + 32'd4);
        idle(); step();

        // Illegal immediates: accepted, dropped, error sticky until cleared
        req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        step();
        req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        step();
        check("ill_err", {31'b0, err_o}, 32'h1);
        check("ill_count", {29'b0, count_o}, 32'h0);
        idle(); clear_err_i = 1'b1; step(); idle();
        check("clr_err", {31'b0, err_o}, 32'h0);
        insn_ready_i = 1'b0;
        req(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        step();
        check("ill_addr_hold", addr_o, BASE + 32'd8);
        // Error set wins over a same-cycle clear
        req(3'd6, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        clear_err_i = 1'b1;
        step();
        check("set_wins", {31'b0, err_o}, 32'h1);
        idle(); clear_err_i = 1'b1; step(); idle();

        // Backpressure with five requests into four slots
        restart_i = 1'b1; step(); idle();
        insn_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
            step();
        end
        check("bp_ready", {31'b0, req_ready_o}, 32'h0);
        check("bp_head", insn_o, 32'h0000_0093);
        check("bp_addr", addr_o, BASE);
        insn_ready_i = 1'b1;
        step();
        check("bp_count", {29'b0, count_o}, 32'd4);
        idle();
        for (int i = 0; i < 4; i++) step();

        // Restart with three queued entries
        insn_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req(3'd0, 7'h33, 5'(i), 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
            step();
        end
        idle(); restart_i = 1'b1;
        req(3'd0, 7'h33, 5'd9, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
        step(); idle();
        check("rs_count", {29'b0, count_o}, 32'h0);
        req(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        step(); idle();
        check("rs_addr", addr_o, BASE);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  f;
            logic [31:0] im;
            f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0: im = $urandom;
                1: begin im = $urandom & 32'hFFF; if (im[11]) im = im | 32'hFFFF_F000; end
                2: begin im = $urandom & 32'h1F_FFFE; if (im[20]) im = im | 32'hFFE0_0000; end
                default: im = $urandom & 32'hFFFF_F000;
            endcase
            req(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                3'($urandom), 7'($urandom), im);
            req_valid_i  = ($urandom_range(0, 9) < 8);
            insn_ready_i = ($urandom_range(0, 9) < 6);
            restart_i    = ($urandom_range(0, 99) < 3);
            clear_err_i  = ($urandom_range(0, 99) < 5);
            step();
        end

        // Asynchronous reset in the middle of traffic
        idle(); insn_ready_i = 1'b0;
        req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        step(); step();
        idle();
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("mid");
        model_reset();
        reset = 1'b1;
        step();
        req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        step(); idle();
        check("post_rst_addr", addr_o, BASE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
